ps2_keyboard_receiver: RTL and testbench
========================================

Name: ps2_keyboard_receiver

Overview:
- Receives PS/2 device-to-host frames on ps_clock/ps_data and emits raw bytes.
- Decodes set-2 scan-code prefixes (E0 extended, F0 break) into single key events.
- Sits between the board PS/2 pins and the lab top logic; its key events feed tone selection for the buzzer and I2S sound path.
- Receive-only: never drives ps_clock or ps_data.

Parameters:
- clk_mhz, 50, system clock frequency in MHz.
- timeout_us, 200, maximum gap between ps_clock falling edges inside a frame before the frame is aborted.
- filter_cycles, 8, consecutive clk cycles a synchronized ps_clock level must hold before the filtered clock follows it.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- ps_clock  input  1  PS/2 clock from device, open-collector, idle high.
- ps_data  input  1  PS/2 data from device, idle high.
- byte_valid  output  1  one-cycle pulse: byte holds a good frame.
- byte  output  8  last good received byte; holds between pulses.
- parity_err  output  1  one-cycle pulse: frame had bad odd parity.
- frame_err  output  1  one-cycle pulse: bad stop bit or timeout.
- key_valid  output  1  one-cycle pulse: new key event.
- key_code  output  8  scan code of last event; holds.
- key_extended  output  1  last event was E0-prefixed; holds.
- key_release  output  1  last event was F0-prefixed (break); holds.

Behaviour:
- Reset: rst low clears everything immediately, regardless of clk.
  - All outputs go to 0.
  - Synchronizers and the filtered clock go to 1.
  - FSM goes to IDLE; bit counter, timeout counter and prefix flags go to 0.
  - Reset mid-frame discards the partial frame. The next complete frame after release decodes normally.
- Input synchronization: 2-FF synchronizer on each input.
- Clock filter:
  - The filter counter increments while the synced ps_clock differs from the filtered clock, and clears when they match.
  - When the count reaches filter_cycles, the filtered clock toggles and the counter clears.
  - A fall is a filtered-clock 1->0 transition. On a fall, ps_data is sampled from its synchronizer in that same cycle.
- FSM, advancing only on a fall:
  - IDLE: data 0 -> DATA with bit_cnt=0; data 1 -> stay.
  - DATA: shift right, sampled bit into [7] (LSB first). After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: evaluate the frame, then -> IDLE.
- STOP evaluation:
  - Stop bit 0 -> frame_err. This takes priority; no byte_valid.
  - Else, if data XOR parity has an even number of ones -> parity_err; no byte_valid.
  - Else -> byte updated and byte_valid.
  - All three outputs pulse in the cycle after the STOP fall.
- Timeout:
  - The counter runs while the FSM is not in IDLE and clears on every fall.
  - At clk_mhz*timeout_us cycles: FSM -> IDLE and frame_err pulses next cycle.
  - Counter width is $clog2(clk_mhz*timeout_us+1).
- Decoder, acting on byte_valid:
  - E0: set ext_pending.
  - F0: set rel_pending.
  - E1, AA, FA, EE, FE, 00, FF: ignored; pending flags unchanged.
  - Any other byte: key_valid pulses the next cycle. key_code=byte, key_extended=ext_pending, key_release=rel_pending; both flags clear.
  - parity_err or frame_err clears both pending flags.
- Latency:
  - key_valid comes 1 cycle after byte_valid, i.e. 2 cycles after the STOP fall.
  - Pulses never last more than 1 cycle.
- Simultaneous events: a fall arriving in the same cycle as the timeout terminal count is treated as the timeout; that fall is ignored.

Test Plan:
All frames are driven at a 12.5 kHz PS/2 clock, with data changed mid-high phase.
- Frame 0x1C, parity 0, stop 1 -> byte_valid once with byte=0x1C; 1 cycle later key_valid with key_code=0x1C, key_extended=0, key_release=0.
- Frames F0,1C -> one byte_valid per frame, exactly one key_valid: code 0x1C, release=1, extended=0.
- Frames E0,F0,75 -> single key_valid: code 0x75, extended=1, release=1. A following frame 0x75 -> extended=0, release=0.
- E0, then 0x1C sent with parity 1, then 0x75 -> parity_err one pulse, no byte_valid for the bad frame; the next event is 0x75 with extended=0.
- Start bit plus 4 data bits, then 250 us silence -> frame_err pulse about 200 us after the last fall, no byte_valid. The following 0x29 frame decodes correctly.
- A 3-clk-cycle low glitch on ps_clock in IDLE -> no state change, no pulses.
- rst low for 2 cycles after bit 5 of a frame -> all outputs 0 immediately; the next full 0x1C frame yields key_valid with code 0x1C.

Source files
------------

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the PS/2 lines,
// deframes 11-bit frames into bytes and folds set-2 E0/F0 prefixes into
// single key events. Receive-only; the PS/2 lines are never driven.
// The raw byte output is named byte_data because "byte" is a reserved word.
`timescale 1ns / 1ps

module ps2_keyboard_receiver #(
  parameter int unsigned clk_mhz       = 50,
  parameter int unsigned timeout_us    = 200,
  parameter int unsigned filter_cycles = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps_clock,
  input  logic       ps_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       parity_err,
  output logic       frame_err,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_release
);

  localparam int unsigned TimeoutCycles = clk_mhz * timeout_us;
  localparam int unsigned ToW           = $clog2(TimeoutCycles + 1);
  localparam int unsigned FiltW         = $clog2(filter_cycles + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Synchronizers
  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

  // Clock filter
  logic             clk_filt_q, clk_filt_d;
  logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
  logic             fall;

  // Frame FSM
  state_e         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           timeout_hit;
  logic           byte_valid_q, byte_valid_d;
  logic [7:0]     byte_data_q, byte_data_d;
  logic           parity_err_q, parity_err_d;
  logic           frame_err_q, frame_err_d;

  // Prefix decoder
  logic       ext_pend_q, ext_pend_d;
  logic       rel_pend_q, rel_pend_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d;
  logic       key_rel_q, key_rel_d;

  // Two-flop synchronizers; idle level is high so they reset to 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps_clock;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps_data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Filtered clock follows the synced clock only after it holds a new level long enough
  always_comb begin
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    if (clk_s2_q != clk_filt_q) begin
      if (filt_cnt_q == FiltW'(filter_cycles - 1)) begin
        clk_filt_d = ~clk_filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
    fall = clk_filt_q & ~clk_filt_d;
  end

  // Filter state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_filt_q <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      clk_filt_q <= clk_filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // Frame FSM next state, timeout and frame result pulses
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    to_cnt_d     = (state_q == StIdle) ? '0 : to_cnt_q + 1'b1;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    timeout_hit  = (state_q != StIdle) && (to_cnt_q == ToW'(TimeoutCycles));

    // Timeout wins over a fall landing in the same cycle
    if (timeout_hit) begin
      state_d     = StIdle;
      to_cnt_d    = '0;
      frame_err_d = 1'b1;
    end else if (fall) begin
      to_cnt_d = '0;
      unique case (state_q)
        StIdle: begin
          if (!dat_s2_q) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end
        end
        StData: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          parity_d = dat_s2_q;
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (!dat_s2_q) begin
            frame_err_d = 1'b1;
          end else if (!(^{shift_q, parity_q})) begin
            parity_err_d = 1'b1;
          end else begin
            byte_valid_d = 1'b1;
            byte_data_d  = shift_q;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Frame FSM state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Prefix decoder: collect E0/F0, skip protocol bytes, emit one event per key byte
  always_comb begin
    ext_pend_d  = ext_pend_q;
    rel_pend_d  = rel_pend_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_rel_d   = key_rel_q;
    if (parity_err_q || frame_err_q) begin
      ext_pend_d = 1'b0;
      rel_pend_d = 1'b0;
    end else if (byte_valid_q) begin
      case (byte_data_q)
        8'hE0: ext_pend_d = 1'b1;
        8'hF0: rel_pend_d = 1'b1;
        8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
        default: begin
          key_valid_d = 1'b1;
          key_code_d  = byte_data_q;
          key_ext_d   = ext_pend_q;
          key_rel_d   = rel_pend_q;
          ext_pend_d  = 1'b0;
          rel_pend_d  = 1'b0;
        end
      endcase
    end
  end

  // Decoder state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_pend_q  <= 1'b0;
      rel_pend_q  <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_rel_q   <= 1'b0;
    end else begin
      ext_pend_q  <= ext_pend_d;
      rel_pend_q  <= rel_pend_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_rel_q   <= key_rel_d;
    end
  end

  assign byte_valid   = byte_valid_q;
  assign byte_data    = byte_data_q;
  assign parity_err   = parity_err_q;
  assign frame_err    = frame_err_q;
  assign key_valid    = key_valid_q;
  assign key_code     = key_code_q;
  assign key_extended = key_ext_q;
  assign key_release  = key_rel_q;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Directed bench for ps2_keyboard_receiver. Runs the DUT at 1 MHz with a
// 200-cycle timeout so a 12.5 kHz PS/2 clock is an 80-cycle period.
`timescale 1ns / 1ps

module tb_ps2_keyboard_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps_clock = 1'b1;
  logic       ps_data = 1'b1;
  logic       byte_valid, parity_err, frame_err, key_valid, key_extended, key_release;
  logic [7:0] byte_data, key_code;

  int vectors = 0;
  int miscompares = 0;

  ps2_keyboard_receiver #(
    .clk_mhz      (1),
    .timeout_us   (200),
    .filter_cycles(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps_clock    (ps_clock),
    .ps_data     (ps_data),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_extended(key_extended),
    .key_release (key_release)
  );

  always #500 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse observer: counts pulses, remembers when they happened, flags wide pulses
  int   bv_n = 0, kv_n = 0, pe_n = 0, fe_n = 0, wide_n = 0;
  int   bv_cyc = 0, kv_cyc = 0, fe_cyc = 0, fall_cyc = 0;
  logic bv_l = 1'b0, kv_l = 1'b0, pe_l = 1'b0, fe_l = 1'b0;
  always @(negedge clk) begin
    if (byte_valid) begin bv_n++; bv_cyc = cyc; end
    if (key_valid)  begin kv_n++; kv_cyc = cyc; end
    if (parity_err) pe_n++;
    if (frame_err)  begin fe_n++; fe_cyc = cyc; end
    if ((byte_valid && bv_l) || (key_valid && kv_l) || (parity_err && pe_l) ||
        (frame_err && fe_l)) wide_n++;
    bv_l = byte_valid; kv_l = key_valid; pe_l = parity_err; fe_l = frame_err;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // {stop, parity, data, start}; odd parity unless bad_par
  function automatic logic [10:0] frame(input logic [7:0] d, input bit bad_par,
                                        input bit bad_stop);
    return {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  // Send the first n bits; data changes mid-high, 40 cycles high then 40 low
  task automatic send_bits(input logic [10:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      tick(20); ps_data = b[i];
      tick(20); ps_clock = 1'b0; fall_cyc = cyc;
      tick(40); ps_clock = 1'b1;
    end
    tick(20); ps_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    send_bits(frame(d, bad_par, bad_stop), 11);
    tick(60);
  endtask

  task automatic test_reset();
    tick(3);
    vectors++; if (byte_valid !== 1'b0) begin miscompares++; $display("FAIL reset_byte_valid: got %b want 0", byte_valid); end
    vectors++; if (byte_data !== 8'h00) begin miscompares++; $display("FAIL reset_byte: got %h want 00", byte_data); end
    vectors++; if ({parity_err, frame_err, key_valid} !== 3'b000) begin miscompares++; $display("FAIL reset_pulses: got %b want 000", {parity_err, frame_err, key_valid}); end
    vectors++; if ({key_code, key_extended, key_release} !== 10'h000) begin miscompares++; $display("FAIL reset_key: got %h want 000", {key_code, key_extended, key_release}); end
    rst = 1'b1;
    tick(5);
  endtask

  task automatic test_make();
    int b0 = bv_n, k0 = kv_n;
    send_frame(8'h1C, 0, 0);
    vectors++; if (bv_n - b0 !== 1) begin miscompares++; $display("FAIL make_bv_count: got %0d want 1", bv_n - b0); end
    vectors++; if (byte_data !== 8'h1C) begin miscompares++; $display("FAIL make_byte: got %h want 1c", byte_data); end
    vectors++; if (kv_n - k0 !== 1) begin miscompares++; $display("FAIL make_kv_count: got %0d want 1", kv_n - k0); end
    vectors++; if (kv_cyc - bv_cyc !== 1) begin miscompares++; $display("FAIL make_latency: got %0d want 1", kv_cyc - bv_cyc); end
    vectors++; if ({key_code, key_extended, key_release} !== {8'h1C, 2'b00}) begin miscompares++; $display("FAIL make_key: got %h/%b%b want 1c/00", key_code, key_extended, key_release); end
  endtask

  task automatic test_break();
    int b0 = bv_n, k0 = kv_n;
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    vectors++; if (bv_n - b0 !== 2) begin miscompares++; $display("FAIL break_bv_count: got %0d want 2", bv_n - b0); end
    vectors++; if (kv_n - k0 !== 1) begin miscompares++; $display("FAIL break_kv_count: got %0d want 1", kv_n - k0); end
    vectors++; if ({key_code, key_extended, key_release} !== {8'h1C, 2'b01}) begin miscompares++; $display("FAIL break_key: got %h/%b%b want 1c/01", key_code, key_extended, key_release); end
  endtask

  task automatic test_ext_break();
    int k0 = kv_n;
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    vectors++; if (kv_n - k0 !== 1) begin miscompares++; $display("FAIL extbrk_kv_count: got %0d want 1", kv_n - k0); end
    vectors++; if ({key_code, key_extended, key_release} !== {8'h75, 2'b11}) begin miscompares++; $display("FAIL extbrk_key: got %h/%b%b want 75/11", key_code, key_extended, key_release); end
    send_frame(8'h75, 0, 0);
    vectors++; if (kv_n - k0 !== 2) begin miscompares++; $display("FAIL plain_kv_count: got %0d want 2", kv_n - k0); end
    vectors++; if ({key_code, key_extended, key_release} !== {8'h75, 2'b00}) begin miscompares++; $display("FAIL plain_key: got %h/%b%b want 75/00", key_code, key_extended, key_release); end
  endtask

  task automatic test_parity();
    int b0 = bv_n, k0 = kv_n, p0 = pe_n;
    send_frame(8'hE0, 0, 0);
    send_frame(8'h1C, 1, 0);
    vectors++; if (pe_n - p0 !== 1) begin miscompares++; $display("FAIL parity_pe_count: got %0d want 1", pe_n - p0); end
    vectors++; if (bv_n - b0 !== 1) begin miscompares++; $display("FAIL parity_bv_count: got %0d want 1", bv_n - b0); end
    vectors++; if (byte_data !== 8'hE0) begin miscompares++; $display("FAIL parity_byte_hold: got %h want e0", byte_data); end
    send_frame(8'h75, 0, 0);
    vectors++; if (kv_n - k0 !== 1) begin miscompares++; $display("FAIL parity_kv_count: got %0d want 1", kv_n - k0); end
    vectors++; if ({key_code, key_extended, key_release} !== {8'h75, 2'b00}) begin miscompares++; $display("FAIL parity_key: got %h/%b%b want 75/00", key_code, key_extended, key_release); end
  endtask

  task automatic test_stop_err();
    int b0 = bv_n, f0 = fe_n, p0 = pe_n;
    send_frame(8'h1C, 1, 1);
    vectors++; if (fe_n - f0 !== 1) begin miscompares++; $display("FAIL stop_fe_count: got %0d want 1", fe_n - f0); end
    vectors++; if ((bv_n - b0) + (pe_n - p0) !== 0) begin miscompares++; $display("FAIL stop_other_pulses: got %0d want 0", (bv_n - b0) + (pe_n - p0)); end
  endtask

  task automatic test_timeout();
    int b0 = bv_n, f0 = fe_n, k0 = kv_n;
    send_bits(frame(8'hA5, 0, 0), 5);
    tick(250);
    vectors++; if (fe_n - f0 !== 1) begin miscompares++; $display("FAIL timeout_fe_count: got %0d want 1", fe_n - f0); end
    vectors++; if (fe_cyc - fall_cyc < 205 || fe_cyc - fall_cyc > 215) begin miscompares++; $display("FAIL timeout_delay: got %0d want 205..215", fe_cyc - fall_cyc); end
    vectors++; if (bv_n - b0 !== 0) begin miscompares++; $display("FAIL timeout_bv_count: got %0d want 0", bv_n - b0); end
    send_frame(8'h29, 0, 0);
    vectors++; if (kv_n - k0 !== 1) begin miscompares++; $display("FAIL timeout_next_kv: got %0d want 1", kv_n - k0); end
    vectors++; if ({key_code, key_extended, key_release} !== {8'h29, 2'b00}) begin miscompares++; $display("FAIL timeout_next_key: got %h/%b%b want 29/00", key_code, key_extended, key_release); end
  endtask

  // Glitch with data low: an unfiltered glitch would start a frame and later time out
  task automatic test_glitch();
    int s0 = bv_n + kv_n + pe_n + fe_n;
    ps_data = 1'b0; ps_clock = 1'b0;
    tick(3);
    ps_clock = 1'b1;
    tick(10);
    ps_data = 1'b1;
    tick(250);
    vectors++; if (bv_n + kv_n + pe_n + fe_n - s0 !== 0) begin miscompares++; $display("FAIL glitch_pulses: got %0d want 0", bv_n + kv_n + pe_n + fe_n - s0); end
  endtask

  task automatic test_async_reset();
    int k0;
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_bits(frame(8'h1C, 0, 0), 6);
    #100 rst = 1'b0;
    #1;
    vectors++; if ({byte_valid, parity_err, frame_err, key_valid} !== 4'b0000) begin miscompares++; $display("FAIL async_pulses: got %b want 0000", {byte_valid, parity_err, frame_err, key_valid}); end
    vectors++; if (byte_data !== 8'h00) begin miscompares++; $display("FAIL async_byte: got %h want 00", byte_data); end
    vectors++; if ({key_code, key_extended, key_release} !== 10'h000) begin miscompares++; $display("FAIL async_key: got %h/%b%b want 00/00", key_code, key_extended, key_release); end
    tick(2);
    rst = 1'b1;
    tick(20);
    k0 = kv_n;
    send_frame(8'h1C, 0, 0);
    vectors++; if (kv_n - k0 !== 1) begin miscompares++; $display("FAIL async_next_kv: got %0d want 1", kv_n - k0); end
    vectors++; if ({key_code, key_extended, key_release} !== {8'h1C, 2'b00}) begin miscompares++; $display("FAIL async_next_key: got %h/%b%b want 1c/00", key_code, key_extended, key_release); end
  endtask

  task automatic test_pulse_width();
    vectors++; if (wide_n !== 0) begin miscompares++; $display("FAIL pulse_width: got %0d wide pulses want 0", wide_n); end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_ext_break();
    test_parity();
    test_stop_err();
    test_timeout();
    test_glitch();
    test_async_reset();
    test_pulse_width();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
